// File: rtl/gat_feat_readback_if.sv
// Output stream bundle of the feature readback block: data, valid, last toward the host DMA, ready back.
interface gat_feat_readback_if #(
    parameter int NEW_FEATURE_WIDTH = 32
);
    logic [NEW_FEATURE_WIDTH-1:0] m_tdata;
    logic                         m_tvalid;
    logic                         m_tready;
    logic                         m_tlast;

    modport master (output m_tdata, output m_tvalid, output m_tlast, input  m_tready);
    modport slave  (input  m_tdata, input  m_tvalid, input  m_tlast, output m_tready);
endinterface

// File: rtl/gat_feat_readback.sv
// Feature-BRAM readback: on a gat_ready rising edge, sweeps port B and streams the words with tlast.
// Optional running checksum of emitted words, enabled by defining GAT_READBACK_CHECKSUM_EN.
module gat_feat_readback #(
    parameter int NEW_FEATURE_WIDTH  = 32,
    parameter int NEW_FEATURE_DEPTH  = 43328,
    parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
    parameter int BRAM_RD_LATENCY    = 2,
    parameter int FIFO_DEPTH         = BRAM_RD_LATENCY + 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          gat_ready,
    input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
    output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
    output logic                          feat_bram_enb,
    input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
    gat_feat_readback_if.master           m_axis,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   checksum
);
    localparam int AW  = NEW_FEATURE_ADDR_W;
    localparam int AW1 = NEW_FEATURE_ADDR_W + 1;
    localparam int LAT = BRAM_RD_LATENCY;
    localparam int CW  = $clog2(FIFO_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = $clog2(FIFO_DEPTH);

    localparam logic [AW:0]   DEPTH_C  = AW1'(NEW_FEATURE_DEPTH);
    localparam logic [AW:0]   ONE_A    = AW1'(1);
    localparam logic [CW:0]   FD_C     = CW1'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                   r_state;
    logic                         r_gat_ready_q;
    logic [AW:0]                  r_len;
    logic [AW:0]                  r_idx;
    logic [AW:0]                  r_ecnt;
    logic [LAT-1:0]               r_vld;
    logic [CW-1:0]                r_infl;
    logic [CW-1:0]                r_cnt;
    logic [PW-1:0]                r_wptr;
    logic [PW-1:0]                r_rptr;
    logic [NEW_FEATURE_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic                         w_start;
    logic                         w_credit;
    logic                         w_enb;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_tvalid;
    logic                         w_tlast;
    logic [AW:0]                  w_len_clip;
    logic [AW:0]                  w_idx_nxt;
    logic [NEW_FEATURE_WIDTH-1:0] w_tdata;

    assign w_start    = gat_ready & ~r_gat_ready_q;
    assign w_len_clip = (num_words > DEPTH_C) ? DEPTH_C : num_words;
    assign w_idx_nxt  = r_idx + ONE_A;
    // Reads in flight plus buffered words may never exceed the FIFO, so backpressure is lossless.
    assign w_credit   = ({1'b0, r_infl} + {1'b0, r_cnt}) < FD_C;
    assign w_enb      = (r_state == S_RUN) && w_credit;
    assign w_push     = r_vld[LAT-1];
    assign w_tvalid   = (r_cnt != '0);
    assign w_tlast    = w_tvalid && (r_ecnt == r_len - ONE_A);
    assign w_pop      = w_tvalid && m_axis.m_tready;
    assign w_tdata    = w_tvalid ? r_mem[r_rptr] : '0;

    assign feat_bram_addrb = {r_idx[AW-1:0], 2'b00};
    assign feat_bram_enb   = w_enb;
    assign m_axis.m_tdata  = w_tdata;
    assign m_axis.m_tvalid = w_tvalid;
    assign m_axis.m_tlast  = w_tlast;
    assign busy            = (r_state != S_IDLE);
    assign done            = (r_state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_gat_ready_q <= 1'b0;
            r_len         <= '0;
            r_idx         <= '0;
            r_ecnt        <= '0;
        end else begin
            r_gat_ready_q <= gat_ready;
            if (w_pop) r_ecnt <= r_ecnt + ONE_A;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_idx   <= '0;
                        r_ecnt  <= '0;
                        r_len   <= w_len_clip;
                        r_state <= (num_words == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_enb) begin
                        r_idx <= w_idx_nxt;
                        if (w_idx_nxt == r_len) r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_pop && w_tlast) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld  <= '0;
            r_infl <= '0;
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            r_vld  <= (r_vld << 1) | LAT'(w_enb);
            r_infl <= r_infl + CW'(w_enb) - CW'(w_push);
            r_cnt  <= r_cnt + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + PW'(1);
            if (w_pop)  r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + PW'(1);
        end
    end

    // Storage only; occupancy and pointers above decide what is valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= feat_bram_dout;
    end

`ifdef GAT_READBACK_CHECKSUM_EN
    logic [31:0] r_csum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csum <= '0;
        end else if ((r_state == S_IDLE) && w_start) begin
            r_csum <= '0;
        end else if (w_pop) begin
            r_csum <= r_csum + 32'(w_tdata);
        end
    end

    assign checksum = r_csum;
`else
    assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_gat_feat_readback.sv
// Directed bench for gat_feat_readback: three instances (read latency 2, 1, 3) share all inputs.
module tb_gat_feat_readback;
    localparam int W     = 32;
    localparam int DEPTH = 40;
    localparam int AW    = $clog2(DEPTH);
    localparam int AW1   = AW + 1;

`ifdef GAT_READBACK_CHECKSUM_EN
    localparam logic [31:0] CSUM_T1 = 32'h406;
`else
    localparam logic [31:0] CSUM_T1 = 32'h0;
`endif

    localparam logic [8:0]  T1_ENB  = 9'b000011110;
    localparam logic [8:0]  T1_VLD  = 9'b011110000;
    localparam logic [8:0]  T1_LAST = 9'b010000000;
    localparam logic [8:0]  T1_DONE = 9'b100000000;
    localparam logic [31:0] T1_ADDR [9] = '{0, 0, 4, 8, 12, 0, 0, 0, 0};
    localparam logic [31:0] T1_DATA [9] = '{0, 0, 0, 0, 'h100, 'h101, 'h102, 'h103, 0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          gat_ready = 1'b0;
    logic          tready = 1'b0;
    logic [AW:0]   num_words = '0;

    logic [AW+1:0] addr0, addr1, addr2;
    logic          enb0, enb1, enb2;
    logic [W-1:0]  dout0, dout1, dout2;
    logic          busy0, busy1, busy2;
    logic          done0, done1, done2;
    logic [31:0]   csum0, csum1, csum2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    gat_feat_readback_if #(.NEW_FEATURE_WIDTH(W)) ax0 ();
    gat_feat_readback_if #(.NEW_FEATURE_WIDTH(W)) ax1 ();
    gat_feat_readback_if #(.NEW_FEATURE_WIDTH(W)) ax2 ();
    assign ax0.m_tready = tready;
    assign ax1.m_tready = tready;
    assign ax2.m_tready = tready;

    gat_feat_readback #(.NEW_FEATURE_DEPTH(DEPTH), .BRAM_RD_LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst), .gat_ready(gat_ready), .num_words(num_words),
        .feat_bram_addrb(addr0), .feat_bram_enb(enb0), .feat_bram_dout(dout0),
        .m_axis(ax0), .busy(busy0), .done(done0), .checksum(csum0));
    gat_feat_readback #(.NEW_FEATURE_DEPTH(DEPTH), .BRAM_RD_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .gat_ready(gat_ready), .num_words(num_words),
        .feat_bram_addrb(addr1), .feat_bram_enb(enb1), .feat_bram_dout(dout1),
        .m_axis(ax1), .busy(busy1), .done(done1), .checksum(csum1));
    gat_feat_readback #(.NEW_FEATURE_DEPTH(DEPTH), .BRAM_RD_LATENCY(3)) u_lat3 (
        .clk(clk), .rst(rst), .gat_ready(gat_ready), .num_words(num_words),
        .feat_bram_addrb(addr2), .feat_bram_enb(enb2), .feat_bram_dout(dout2),
        .m_axis(ax2), .busy(busy2), .done(done2), .checksum(csum2));

    // BRAM models: word i holds 0x100+i, visible LAT cycles after the address was driven.
    logic [AW+1:0] d0 [2];
    logic [AW+1:0] d1 [1];
    logic [AW+1:0] d2 [3];
    always @(posedge clk) begin
        d0[0] <= addr0; d0[1] <= d0[0];
        d1[0] <= addr1;
        d2[0] <= addr2; d2[1] <= d2[0]; d2[2] <= d2[1];
    end
    assign dout0 = 32'h100 + 32'(d0[1] >> 2);
    assign dout1 = 32'h100 + 32'(d1[0] >> 2);
    assign dout2 = 32'h100 + 32'(d2[2] >> 2);

    int            n_enb [3];
    int            n_last [3];
    int            n_done [3];
    logic [AW+1:0] last_addr [3];
    logic [32:0]   q0 [$];
    logic [32:0]   q1 [$];
    logic [32:0]   q2 [$];
    int            q_base [3];
    int            last_base [3];
    int            done_base [3];
    int            enb_base [3];

    always @(negedge clk) begin
        if (enb0) begin n_enb[0]++; last_addr[0] = addr0; end
        if (enb1) begin n_enb[1]++; last_addr[1] = addr1; end
        if (enb2) begin n_enb[2]++; last_addr[2] = addr2; end
        if (ax0.m_tvalid && tready) begin q0.push_back({ax0.m_tlast, ax0.m_tdata}); if (ax0.m_tlast) n_last[0]++; end
        if (ax1.m_tvalid && tready) begin q1.push_back({ax1.m_tlast, ax1.m_tdata}); if (ax1.m_tlast) n_last[1]++; end
        if (ax2.m_tvalid && tready) begin q2.push_back({ax2.m_tlast, ax2.m_tdata}); if (ax2.m_tlast) n_last[2]++; end
        if (done0) n_done[0]++;
        if (done1) n_done[1]++;
        if (done2) n_done[2]++;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [32:0] beat(input int d, input int i);
        case (d)
            0:       return q0[i];
            1:       return q1[i];
            default: return q2[i];
        endcase
    endfunction

    task automatic snap();
        for (int d = 0; d < 3; d++) begin
            q_base[d]    = qsize(d);
            last_base[d] = n_last[d];
            done_base[d] = n_done[d];
            enb_base[d]  = n_enb[d];
        end
    endtask

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic drop();
        @(posedge clk); #1;
        gat_ready = 1'b0;
    endtask

    task automatic start(input int n);
        @(posedge clk); #1;
        num_words = AW1'(n);
        gat_ready = 1'b1;
    endtask

    task automatic wait_done(input string tag, input bit rnd);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge clk); #1;
            if (rnd) tready = 1'($urandom_range(0, 1));
            @(negedge clk); #1;
            ok = (n_done[0] > done_base[0]) && (n_done[1] > done_base[1]) && (n_done[2] > done_base[2]);
        end
        tready = 1'b1;
        chk_eq(tag, 64'(ok), 64'(1));
    endtask

    task automatic check_run(input int d, input int n, input string tag);
        int          got_n;
        logic [32:0] b;
        got_n = qsize(d) - q_base[d];
        chk_eq({tag, "_count"}, 64'(got_n), 64'(n));
        chk_eq({tag, "_nlast"}, 64'(n_last[d] - last_base[d]), 64'(1));
        for (int i = 0; i < n && i < got_n; i++) begin
            b = beat(d, q_base[d] + i);
            chk_eq({tag, "_data"}, 64'(b[31:0]), 64'(32'h100 + i));
            chk_eq({tag, "_last"}, 64'(b[32]), 64'(i == n - 1));
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk_eq({tag, "_addr"},   64'(addr0),        64'(0));
        chk_eq({tag, "_enb"},    64'(enb0),         64'(0));
        chk_eq({tag, "_tdata"},  64'(ax0.m_tdata),  64'(0));
        chk_eq({tag, "_tvalid"}, 64'(ax0.m_tvalid), 64'(0));
        chk_eq({tag, "_tlast"},  64'(ax0.m_tlast),  64'(0));
        chk_eq({tag, "_busy"},   64'(busy0),        64'(0));
        chk_eq({tag, "_done"},   64'(done0),        64'(0));
        chk_eq({tag, "_csum"},   64'(csum0),        64'(0));
    endtask

    initial begin
        repeat (2) tick();
        check_reset_outs("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) tick();

        // Four words, ready held high: cycle-exact against hand tables
        snap();
        tready = 1'b1;
        start(4);
        for (int c = 0; c <= 8; c++) begin
            tick();
            chk_eq("t1_enb", 64'(enb0), 64'(T1_ENB[c]));
            if (T1_ENB[c]) chk_eq("t1_addr", 64'(addr0), 64'(T1_ADDR[c]));
            chk_eq("t1_tvalid", 64'(ax0.m_tvalid), 64'(T1_VLD[c]));
            if (T1_VLD[c]) chk_eq("t1_tdata", 64'(ax0.m_tdata), 64'(T1_DATA[c]));
            chk_eq("t1_tlast", 64'(ax0.m_tlast), 64'(T1_LAST[c]));
            chk_eq("t1_done", 64'(done0), 64'(T1_DONE[c]));
            chk_eq("t1_busy", 64'(busy0), 64'(c != 0));
            if (c == 8) chk_eq("t1_csum_done", 64'(csum0), 64'(CSUM_T1));
        end
        wait_done("t1_timeout", 1'b0);
        chk_eq("t1_csum_hold", 64'(csum0), 64'(CSUM_T1));
        chk_eq("t1_csum_lat1", 64'(csum1), 64'(CSUM_T1));
        chk_eq("t1_csum_lat3", 64'(csum2), 64'(CSUM_T1));
        for (int d = 0; d < 3; d++) check_run(d, 4, "t1");

        // Second rising edge while running must be ignored
        drop();
        snap();
        start(4);
        tick();
        drop();
        @(posedge clk); #1;
        gat_ready = 1'b1;
        wait_done("ign_timeout", 1'b0);
        repeat (10) tick();
        for (int d = 0; d < 3; d++) begin
            check_run(d, 4, "ign");
            chk_eq("ign_ndone", 64'(n_done[d] - done_base[d]), 64'(1));
            chk_eq("ign_nenb", 64'(n_enb[d] - enb_base[d]), 64'(4));
        end

        // Backpressure: ready low for the first 10 cycles of a 16-word run
        drop();
        tready = 1'b0;
        snap();
        start(16);
        for (int c = 0; c < 10; c++) begin
            tick();
            if (c >= 4) begin
                chk_eq("bp_tvalid", 64'(ax0.m_tvalid), 64'(1));
                chk_eq("bp_tdata_hold", 64'(ax0.m_tdata), 64'(32'h100));
            end
        end
        chk_eq("bp_issued", 64'(n_enb[0] - enb_base[0]), 64'(4));
        @(posedge clk); #1;
        tready = 1'b1;
        tick();
        chk_eq("bp_enb_full", 64'(enb0), 64'(0));
        tick();
        chk_eq("bp_enb_resume", 64'(enb0), 64'(1));
        chk_eq("bp_addr_resume", 64'(addr0), 64'(16));
        wait_done("bp_timeout", 1'b0);
        for (int d = 0; d < 3; d++) check_run(d, 16, "bp");

        // Zero-length start: immediate done, no reads, no beats
        drop();
        snap();
        start(0);
        tick();
        chk_eq("z_done_n", 64'(done0), 64'(0));
        tick();
        chk_eq("z_done_n1", 64'(done0), 64'(1));
        chk_eq("z_busy_n1", 64'(busy0), 64'(1));
        chk_eq("z_done_lat1", 64'(done1), 64'(1));
        chk_eq("z_done_lat3", 64'(done2), 64'(1));
        tick();
        chk_eq("z_done_n2", 64'(done0), 64'(0));
        chk_eq("z_busy_n2", 64'(busy0), 64'(0));
        chk_eq("z_busy_lat1", 64'(busy1), 64'(0));
        chk_eq("z_busy_lat3", 64'(busy2), 64'(0));
        repeat (4) tick();
        for (int d = 0; d < 3; d++) begin
            chk_eq("z_nenb", 64'(n_enb[d] - enb_base[d]), 64'(0));
            chk_eq("z_nbeat", 64'(qsize(d) - q_base[d]), 64'(0));
        end

        // Oversized request clips to the BRAM depth
        drop();
        snap();
        start(DEPTH + 5);
        wait_done("clip_timeout", 1'b0);
        for (int d = 0; d < 3; d++) begin
            check_run(d, DEPTH, "clip");
            chk_eq("clip_last_addr", 64'(last_addr[d]), 64'((DEPTH - 1) * 4));
            chk_eq("clip_nenb", 64'(n_enb[d] - enb_base[d]), 64'(DEPTH));
        end

        // Asynchronous reset mid-stream, then a clean restart from address 0
        drop();
        snap();
        start(16);
        repeat (5) tick();
        chk_eq("mr_pre_tvalid", 64'(ax0.m_tvalid), 64'(1));
        rst = 1'b1;
        gat_ready = 1'b0;
        #1;
        check_reset_outs("mrst");
        @(posedge clk); #1;
        rst = 1'b0;
        drop();
        snap();
        start(16);
        tick();
        tick();
        chk_eq("mr_enb", 64'(enb0), 64'(1));
        chk_eq("mr_addr0", 64'(addr0), 64'(0));
        wait_done("mr_timeout", 1'b0);
        for (int d = 0; d < 3; d++) check_run(d, 16, "mr");

        // Random ready on all three latencies
        drop();
        snap();
        start(20);
        wait_done("rnd_timeout", 1'b1);
        for (int d = 0; d < 3; d++) check_run(d, 20, "rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/gat_feat_readback.md
# gat_feat_readback

Reader for the GAT new-feature output BRAM: on completion of a layer (`gat_ready` rising edge) it sweeps the feature BRAM port B with byte addresses, absorbs the fixed BRAM read latency, and presents the words as a valid/ready stream with `last` toward the host DMA. It sits between the accelerator's `feat_bram_addrb`/`feat_bram_dout` pair and the PS-side stream interconnect. Backpressure is lossless, using a credit-limited output FIFO.

## Interface
- `NEW_FEATURE_WIDTH`, 32: feature word width.
- `NEW_FEATURE_DEPTH`, 43328: BRAM depth in words.
- `NEW_FEATURE_ADDR_W`, $clog2(NEW_FEATURE_DEPTH): word address width.
- `BRAM_RD_LATENCY`, 2: cycles from `feat_bram_enb` high to valid `feat_bram_dout`; legal range is ≥1.
- `FIFO_DEPTH`, BRAM_RD_LATENCY+2: output buffer entries.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `gat_ready` in 1: layer-complete level from the accelerator. Its rising edge starts a readback.
- `num_words` in NEW_FEATURE_ADDR_W+1: word count, sampled on the start edge.
- `feat_bram_addrb` out NEW_FEATURE_ADDR_W+2: byte address, always 4×word index, so bits [1:0] are 0.
- `feat_bram_enb` out 1: read enable, one word per high cycle.
- `feat_bram_dout` in NEW_FEATURE_WIDTH: read data.
- `m_tdata` out NEW_FEATURE_WIDTH: stream data.
- `m_tvalid` out 1: stream valid.
- `m_tready` in 1: stream ready.
- `m_tlast` out 1: marks the final word.
- `busy` out 1: high while a readback is in progress.
- `done` out 1: one-cycle completion pulse.
- `checksum` out 32: running sum of emitted words. See Configuration.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- Start detection: `gat_ready` is registered into `gat_ready_q`. Start = `gat_ready & ~gat_ready_q`. The start is acted on only in IDLE and ignored in every other state.
- IDLE → RUN on start when `num_words` ≠ 0.
  - Length latches as min(`num_words`, NEW_FEATURE_DEPTH).
  - Issue index clears to 0.
- IDLE → DONE on start when `num_words` = 0. No BRAM reads and no stream beats occur.
- RUN: `feat_bram_enb` is high when credits are available: (words in flight + FIFO occupancy) < FIFO_DEPTH.
  - Each enabled cycle drives `feat_bram_addrb` = index<<2, then increments the index.
  - RUN → DRAIN when the index reaches the latched length.
- Read data: a delay line of BRAM_RD_LATENCY valid bits tracks each issued read. When a bit matures, `feat_bram_dout` is written into the FIFO. Credits guarantee the FIFO never overflows.
- Stream output:
  - `m_tvalid` = FIFO not empty.
  - `m_tdata` = FIFO head.
  - A beat completes on `m_tvalid & m_tready` and pops the FIFO.
  - `m_tdata` and `m_tlast` hold stable while `m_tvalid & ~m_tready`.
- `m_tlast` is high on the beat with emitted count = length−1.
- DRAIN → DONE once the final beat has handshaked.
- DONE: `done` = 1 for one cycle, then the FSM returns to IDLE.
- `busy` = 1 in RUN, DRAIN and DONE.
- Reset (async, any state):
  - FSM returns to IDLE.
  - Counters, delay line and FIFO clear.
  - In-flight BRAM data is discarded.

## Timing
- Reset values: `feat_bram_addrb`=0, `feat_bram_enb`=0, `m_tdata`=0, `m_tvalid`=0, `m_tlast`=0, `busy`=0, `done`=0, `checksum`=0.
- Start edge sampled in cycle N → RUN in N+1; first `feat_bram_enb` with address 0 in N+1.
- First `m_tvalid` in N+2+BRAM_RD_LATENCY.
- With `m_tready` held high, the block sustains one beat per cycle and emits no bubbles after the first word.
- `done` pulses in the cycle after the final handshake.
- With zero words, `done` pulses in cycle N+1.
- Full pipeline: with `m_tready` low, `feat_bram_enb` stops after FIFO_DEPTH issued-but-unconsumed words. It resumes the cycle after a pop frees a credit.

## Configuration
- `GAT_READBACK_CHECKSUM_EN` defined:
  - `checksum` clears on the start edge.
  - It then accumulates `m_tdata` modulo 2^32 on each handshake.
  - It is stable and valid in the `done` cycle and holds until the next start.
- `GAT_READBACK_CHECKSUM_EN` undefined: `checksum` is tied to 0 and no adder is synthesized.

## Test plan
- Reset, then drive `gat_ready` 0→1 with `num_words`=4, BRAM word i = 0x100+i, `m_tready`=1:
  - Addresses 0,4,8,12 appear on consecutive cycles.
  - Beats 0x100..0x103 follow, with `m_tlast` on 0x103.
  - `done` pulses one cycle later and `checksum` = 0x406.
- Backpressure, same setup with `num_words`=16 and `m_tready` low for 10 cycles:
  - At most FIFO_DEPTH=4 reads are issued during the stall.
  - All 16 words arrive in order with no loss or duplication.
  - `m_tdata` holds stable during the stall.
- `num_words`=0 start: no `feat_bram_enb`, no `m_tvalid`, and `done` pulses in cycle N+1.
- `num_words`=NEW_FEATURE_DEPTH+5: exactly NEW_FEATURE_DEPTH beats are emitted and the last address is (DEPTH−1)<<2.
- Second `gat_ready` edge while busy is ignored. Separately, asserting `rst` mid-RUN forces every output to its reset value immediately, and a later start emits from address 0.
- Randomized `m_tready` with BRAM_RD_LATENCY=1 and 3: the emitted sequence matches the BRAM contents and there is exactly one `m_tlast` per run.
